jt49_eg_ctl: RTL and testbench
==============================

JT49_EG_CTL -- requirements
Module: jt49_eg_ctl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cen  input  1  clock enable; marks one prescaled PSG tick.
REQ-005 wr_n  input  1  active-low register write strobe, sampled every clk regardless of cen.
REQ-006 addr  input  4  register address.
REQ-007 din  input  8  write data.
REQ-008 step  output  1  envelope step square wave; one rising edge per envelope tick.
REQ-009 null_period  output  1  high while the 16-bit envelope period equals 0.
REQ-010 restart  output  1  single-clk pulse requesting envelope restart.
REQ-011 ctrl  output  4  envelope shape {CONT,ATT,ALT,HOLD}.
REQ-012 period  output  16  current envelope period {coarse,fine}.

Function
REQ-013 Write = wr_n low on a clk edge; addr 4'hB loads period[7:0], 4'hC loads period[15:8], 4'hD loads ctrl <= din[3:0]; other addresses ignored.
REQ-014 A write to 4'hD SHALL assert restart for exactly the next clk cycle (not cen-qualified), even if ctrl value is unchanged.
REQ-015 Back-to-back 4'hD writes on consecutive clks SHALL keep restart high for each cycle following a write.
REQ-016 A write to 4'hD SHALL clear the divider counter and drive step low on the next clk edge.
REQ-017 Divider: 16-bit counter cnt; on a cen cycle, if cnt+1 >= period then cnt <= 0 and step toggles, else cnt <= cnt+1.
REQ-018 Compare in REQ-017 uses unsigned 17-bit arithmetic; no wrap at cnt = 16'hFFFF.
REQ-019 Resulting rate: one step rising edge per 2*period cen ticks for period >= 1; period = 1 toggles step every cen.
REQ-020 period = 0: null_period = 1 combinationally from registered period; cnt held at 0; step held at its current value.
REQ-021 Period write lowering period below cnt: next cen cycle wraps (cnt <= 0, step toggles); no long count-out.
REQ-022 Simultaneous cen and period write: divider uses the pre-write period that cycle; new value applies from next cen.
REQ-023 Simultaneous cen and 4'hD write: clear of REQ-016 wins; step = 0, cnt = 0.
REQ-024 Outside cen cycles cnt and step SHALL not change except via REQ-016.
REQ-025 Register writes SHALL take effect regardless of cen.

Reset
REQ-026 On rst_n low, asynchronously: period = 0, ctrl = 0, cnt = 0, step = 0, restart = 0; null_period therefore 1.
REQ-027 Reset asserted mid-count or during a restart pulse SHALL abort it; no restart pulse emitted after release.
REQ-028 First write after rst_n release SHALL be honoured on the first clk edge.

Structure
REQ-029 Register address constants (ENV_FINE=4'hB, ENV_COARSE=4'hC, ENV_SHAPE=4'hD) and ctrl bit indices SHALL live in shared package jt49_pkg.
REQ-030 The divider (cnt, compare, step toggle, clear) SHALL be one sub-module jt49_eg_div; register decode and restart stay in the top.

Verification
REQ-031 Reset, then write B=8'h03, C=8'h00, cen every clk -> step rises every 6 cen; null_period = 0.
REQ-032 Write D=4'hE with cen low 20 clks -> restart high exactly 1 clk, ctrl = 4'hE, step = 0, cnt = 0.
REQ-033 Period 16'h0100, wait cnt = 8'h80, write B=8'h10, C=8'h00 -> wrap and step toggle on very next cen.
REQ-034 Write B=0, C=0 -> null_period = 1, step frozen for 50 cen; then B=1 -> step toggles every cen.
REQ-035 cen and D-write on same clk at cnt+1 = period -> step = 0, cnt = 0, restart 1 clk.
REQ-036 Assert rst_n low during restart pulse and mid-count -> all outputs at REQ-026 values immediately, no pulse after release.

Source files
------------

// File: rtl/jt49_pkg.sv
// Shared PSG definitions: register addresses, envelope shape bit positions and
// the envelope divider wrap test.
package jt49_pkg;

  localparam logic [3:0] ENV_FINE   = 4'hB;
  localparam logic [3:0] ENV_COARSE = 4'hC;
  localparam logic [3:0] ENV_SHAPE  = 4'hD;

  // Bit positions inside ctrl = {CONT, ATT, ALT, HOLD}
  localparam int unsigned CTRL_HOLD = 0;
  localparam int unsigned CTRL_ALT  = 1;
  localparam int unsigned CTRL_ATT  = 2;
  localparam int unsigned CTRL_CONT = 3;

  // 17-bit compare so cnt = 16'hFFFF never wraps the sum back to zero
  function automatic logic env_wrap(input logic [15:0] cnt, input logic [15:0] period);
    return ({1'b0, cnt} + 17'd1) >= {1'b0, period};
  endfunction

endpackage

// File: rtl/jt49_eg_div.sv
// Envelope period divider: counts cen ticks against period and toggles step,
// so step rises once every 2*period ticks.
module jt49_eg_div
  import jt49_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        clr,
  input  logic [15:0] period,
  output logic        step
);

  logic [15:0] cnt_q, cnt_d;
  logic        step_q, step_d;

  always_comb begin
    cnt_d  = cnt_q;
    step_d = step_q;
    if (clr) begin
      cnt_d  = '0;
      step_d = 1'b0;
    end else if (cen) begin
      if (period == 16'd0) begin
        // Null period freezes the envelope where it stands
        cnt_d = '0;
      end else if (env_wrap(cnt_q, period)) begin
        cnt_d  = '0;
        step_d = ~step_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/jt49_eg_ctl.sv
// Envelope register file and restart logic; the period divider lives in
// jt49_eg_div and always sees the registered (pre-write) period.
module jt49_eg_ctl
  import jt49_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        wr_n,
  input  logic [3:0]  addr,
  input  logic [7:0]  din,
  output logic        step,
  output logic        null_period,
  output logic        restart,
  output logic [3:0]  ctrl,
  output logic [15:0] period
);

  logic [15:0] period_q, period_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        restart_q;
  logic        shape_wr;

  assign shape_wr = !wr_n && (addr == ENV_SHAPE);

  always_comb begin
    period_d = period_q;
    ctrl_d   = ctrl_q;
    if (!wr_n) begin
      unique case (addr)
        ENV_FINE:   period_d[7:0]  = din;
        ENV_COARSE: period_d[15:8] = din;
        ENV_SHAPE:  ctrl_d         = din[3:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q  <= '0;
      ctrl_q    <= '0;
      restart_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      ctrl_q    <= ctrl_d;
      restart_q <= shape_wr;
    end
  end

  jt49_eg_div u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .clr    (shape_wr),
    .period (period_q),
    .step   (step)
  );

  assign period      = period_q;
  assign null_period = (period_q == 16'd0);
  assign restart     = restart_q;
  assign ctrl        = {ctrl_q[CTRL_CONT], ctrl_q[CTRL_ATT], ctrl_q[CTRL_ALT], ctrl_q[CTRL_HOLD]};

endmodule

// File: tb/tb_jt49_eg_ctl.sv
// Directed bench for jt49_eg_ctl: register writes, divider rate, restart,
// period edge cases and asynchronous reset abort.
module tb_jt49_eg_ctl;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        wr_n;
  logic [3:0]  addr;
  logic [7:0]  din;
  logic        step;
  logic        null_period;
  logic        restart;
  logic [3:0]  ctrl;
  logic [15:0] period;

  int pass_cnt  = 0;
  int total_cnt = 0;

  jt49_eg_ctl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .wr_n        (wr_n),
    .addr        (addr),
    .din         (din),
    .step        (step),
    .null_period (null_period),
    .restart     (restart),
    .ctrl        (ctrl),
    .period      (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic c);
    wr_n = 1'b0;
    addr = a;
    din  = d;
    cen  = c;
    tick();
    wr_n = 1'b1;
    cen  = 1'b0;
  endtask

  task automatic cen_ticks(input int n);
    cen = 1'b1;
    repeat (n) tick();
    cen = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cen   = 1'b0;
    wr_n  = 1'b1;
    addr  = '0;
    din   = '0;
    #12;
    total_cnt++;
    if ({period, ctrl, step, restart, null_period} !== {16'h0000, 4'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: got p=%h c=%h s=%b r=%b n=%b want p=0000 c=0 s=0 r=0 n=1",
               period, ctrl, step, restart, null_period);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rate();
    int rises = 0;
    int first = -1;
    logic prev;
    wr(4'hB, 8'h03, 1'b0);
    wr(4'hC, 8'h00, 1'b0);
    total_cnt++;
    if (period !== 16'h0003 || null_period !== 1'b0)
      $display("FAIL rate_period: got p=%h n=%b want p=0003 n=0", period, null_period);
    else pass_cnt++;
    prev = step;
    cen = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (!prev && step) begin
        rises++;
        if (first < 0) first = k;
      end
      prev = step;
    end
    cen = 1'b0;
    total_cnt++;
    if (first !== 3) $display("FAIL rate_first_rise: got %0d want 3", first);
    else pass_cnt++;
    total_cnt++;
    if (rises !== 5) $display("FAIL rate_rise_count: got %0d want 5", rises);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    int extra = 0;
    wr(4'hD, 8'h0E, 1'b0);
    total_cnt++;
    if ({restart, ctrl, step} !== {1'b1, 4'hE, 1'b0} || dut.u_div.cnt_q !== 16'h0)
      $display("FAIL restart_pulse: got r=%b c=%h s=%b cnt=%h want r=1 c=e s=0 cnt=0000",
               restart, ctrl, step, dut.u_div.cnt_q);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (restart) extra++;
    end
    total_cnt++;
    if (extra !== 0 || step !== 1'b0 || dut.u_div.cnt_q !== 16'h0)
      $display("FAIL restart_single: got extra=%0d s=%b cnt=%h want 0 0 0000",
               extra, step, dut.u_div.cnt_q);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int highs = 0;
    wr_n = 1'b0;
    addr = 4'hD;
    din  = 8'h0E;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (restart) highs++;
    end
    wr_n = 1'b1;
    total_cnt++;
    if (highs !== 3) $display("FAIL b2b_restart: got %0d high cycles want 3", highs);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (restart !== 1'b0) $display("FAIL b2b_release: got r=%b want 0", restart);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    wr(4'hB, 8'h00, 1'b0);
    wr(4'hC, 8'h01, 1'b0);
    wr(4'hD, 8'h00, 1'b0);
    cen_ticks(128);
    total_cnt++;
    if (dut.u_div.cnt_q !== 16'h0080 || step !== 1'b0)
      $display("FAIL wrap_count: got cnt=%h s=%b want 0080 0", dut.u_div.cnt_q, step);
    else pass_cnt++;
    wr(4'hB, 8'h10, 1'b0);
    wr(4'hC, 8'h00, 1'b0);
    total_cnt++;
    if (period !== 16'h0010 || dut.u_div.cnt_q !== 16'h0080 || step !== 1'b0)
      $display("FAIL wrap_hold: got p=%h cnt=%h s=%b want 0010 0080 0",
               period, dut.u_div.cnt_q, step);
    else pass_cnt++;
    cen_ticks(1);
    total_cnt++;
    if (dut.u_div.cnt_q !== 16'h0000 || step !== 1'b1)
      $display("FAIL wrap_toggle: got cnt=%h s=%b want 0000 1", dut.u_div.cnt_q, step);
    else pass_cnt++;
  endtask

  task automatic test_null();
    int changes = 0;
    logic [3:0] seq;
    logic [3:0] want_seq;
    wr(4'hB, 8'h00, 1'b0);
    wr(4'hC, 8'h00, 1'b0);
    total_cnt++;
    if (null_period !== 1'b1) $display("FAIL null_flag: got %b want 1", null_period);
    else pass_cnt++;
    cen = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (step !== 1'b1) changes++;
    end
    cen = 1'b0;
    total_cnt++;
    if (changes !== 0 || dut.u_div.cnt_q !== 16'h0)
      $display("FAIL null_frozen: got %0d moved cycles cnt=%h want 0 0000",
               changes, dut.u_div.cnt_q);
    else pass_cnt++;
    wr(4'hB, 8'h01, 1'b0);
    cen = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      tick();
      seq[i] = step;
    end
    cen = 1'b0;
    want_seq = 4'b0101;
    total_cnt++;
    if (seq !== want_seq || null_period !== 1'b0)
      $display("FAIL period1_toggle: got seq=%b n=%b want 0101 0", seq, null_period);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    wr(4'hB, 8'h03, 1'b0);
    wr(4'hD, 8'h00, 1'b0);
    cen_ticks(2);
    wr(4'hD, 8'h05, 1'b1);
    total_cnt++;
    if (step !== 1'b0 || dut.u_div.cnt_q !== 16'h0 || restart !== 1'b1 || ctrl !== 4'h5)
      $display("FAIL cen_shape_clear: got s=%b cnt=%h r=%b c=%h want 0 0000 1 5",
               step, dut.u_div.cnt_q, restart, ctrl);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (restart !== 1'b0) $display("FAIL cen_shape_pulse: got r=%b want 0", restart);
    else pass_cnt++;
    cen_ticks(2);
    wr(4'hB, 8'h10, 1'b1);
    total_cnt++;
    if (period !== 16'h0010 || dut.u_div.cnt_q !== 16'h0 || step !== 1'b1)
      $display("FAIL cen_period_old: got p=%h cnt=%h s=%b want 0010 0000 1",
               period, dut.u_div.cnt_q, step);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    wr(4'hD, 8'h09, 1'b0);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({period, ctrl, step, restart, null_period} !== {16'h0000, 4'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_restart: got p=%h c=%h s=%b r=%b n=%b want 0000 0 0 0 1",
               period, ctrl, step, restart, null_period);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (restart) pulses++;
    end
    total_cnt++;
    if (pulses !== 0) $display("FAIL reset_no_pulse: got %0d pulses want 0", pulses);
    else pass_cnt++;
    wr(4'hB, 8'h02, 1'b0);
    cen_ticks(3);
    total_cnt++;
    if (step !== 1'b1 || dut.u_div.cnt_q !== 16'h0001)
      $display("FAIL midcount_setup: got s=%b cnt=%h want 1 0001", step, dut.u_div.cnt_q);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (step !== 1'b0 || dut.u_div.cnt_q !== 16'h0 || period !== 16'h0 || null_period !== 1'b1)
      $display("FAIL reset_midcount: got s=%b cnt=%h p=%h n=%b want 0 0000 0000 1",
               step, dut.u_div.cnt_q, period, null_period);
    else pass_cnt++;
    rst_n = 1'b1;
    wr(4'hB, 8'h07, 1'b0);
    total_cnt++;
    if (period !== 16'h0007 || restart !== 1'b0)
      $display("FAIL first_write: got p=%h r=%b want 0007 0", period, restart);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rate();
    test_restart();
    test_back_to_back();
    test_wrap();
    test_null();
    test_simultaneous();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
